// File: rtl/ram_word_loader.sv
// ram_word_loader: packs a B-bit byte stream little-endian into M-bit words and writes them to consecutive RAM addresses.
// Define LOADER_SKIP_ADR0_EN to keep the loader away from address 0, which the RAM hard-wires to zero.
module ram_word_loader #(
  parameter int N = 4,
  parameter int M = 32,
  parameter int B = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] base_adr,
  input  logic [N:0]   count,
  input  logic [B-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic         we,
  output logic [N-1:0] adr,
  output logic [M-1:0] din,
  output logic         busy,
  output logic         done
);
  localparam int K = M / B;
  localparam int KW = K > 1 ? $clog2(K) : 1;
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
  state_t state, nxt;
  logic [N-1:0] cur_adr, start_adr, next_adr;
  logic [N:0] remaining, start_cnt;
  logic [KW-1:0] bcnt;
  logic [M-1:0] word;
  logic take, last_byte;
`ifdef LOADER_SKIP_ADR0_EN
  assign start_adr = base_adr == '0 ? N'(1) : base_adr;
  assign start_cnt = count[N] ? {1'b0, {N{1'b1}}} : count;
  assign next_adr  = &cur_adr ? N'(1) : cur_adr + N'(1);
`else
  assign start_adr = base_adr;
  assign start_cnt = count;
  assign next_adr  = cur_adr + N'(1);
`endif
  assign take      = state == COLLECT && s_valid;
  assign last_byte = bcnt == KW'(K - 1);
  assign s_ready   = state == COLLECT;
  assign we        = state == WRITE;
  assign busy      = state == COLLECT || state == WRITE;
  assign done      = state == DONE;
  assign adr       = we ? cur_adr : '0;
  assign din       = we ? word : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = start_cnt == '0 ? DONE : COLLECT;
      COLLECT: if (take && last_byte) nxt = WRITE;
      WRITE:   nxt = remaining == (N+1)'(1) ? DONE : COLLECT;
      default: nxt = IDLE;
    endcase
  end
  // bcnt wraps to 0 on the last byte, so every word starts collecting at index 0
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur_adr   <= '0;
      remaining <= '0;
      bcnt      <= '0;
      word      <= '0;
    end else begin
      if (state == IDLE && start) begin
        cur_adr   <= start_adr;
        remaining <= start_cnt;
        bcnt      <= '0;
      end
      if (take) begin
        word[B*bcnt +: B] <= s_data;
        bcnt              <= last_byte ? '0 : bcnt + KW'(1);
      end
      if (state == WRITE) begin
        cur_adr   <= next_adr;
        remaining <= remaining - (N+1)'(1);
      end
    end
endmodule

// File: tb/tb_ram_word_loader.sv
// tb_ram_word_loader: directed loads checked against a write scoreboard built from an address/word model.
module tb_ram_word_loader;
  localparam int N = 4, M = 32, B = 8, K = M / B;
  logic clk, rst_n, start, s_valid;
  logic [N-1:0] base_adr;
  logic [N:0] count;
  logic [B-1:0] s_data;
  logic s_ready, we, busy, done;
  logic [N-1:0] adr;
  logic [M-1:0] din;
  int vecs = 0, errs = 0, cyc = 0, nwr = 0;
  logic prev_we = 0;
  logic [63:0] sb[$];

  ram_word_loader #(.N(N), .M(M), .B(B)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_adr(base_adr), .count(count),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .we(we), .adr(adr),
    .din(din), .busy(busy), .done(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && we) begin
      nwr++;
      check("we_pulse_width", 64'(prev_we), 64'd0);
      if (sb.size() == 0) check("spurious_we", 64'(we), 64'd0);
      else check("write", {28'd0, adr, din}, sb.pop_front());
    end
    prev_we = we;
  end

  function automatic logic [N-1:0] model_next(input logic [N-1:0] a);
`ifdef LOADER_SKIP_ADR0_EN
    return a == '1 ? N'(1) : a + N'(1);
`else
    return a + N'(1);
`endif
  endfunction

  task automatic run_load(input logic [N-1:0] base, input int cnt, input logic [7:0] b0,
                          input logic [7:0] step, input bit gap, input bit poke);
    logic [N-1:0] a = base;
    int c = cnt, t0;
    logic [M-1:0] w;
    bit acc;
`ifdef LOADER_SKIP_ADR0_EN
    if (a == 0) a = 1;
    if (c > (1 << N) - 1) c = (1 << N) - 1;
`endif
    for (int wi = 0; wi < c; wi++) begin
      for (int j = 0; j < K; j++) w[8*j +: 8] = b0 + step * 8'(wi * K + j);
      sb.push_back({28'd0, a, w});
      a = model_next(a);
    end
    start = 1; base_adr = base; count = (N+1)'(cnt); t0 = cyc;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < c * K; i++) begin
      s_data = b0 + step * 8'(i);
      s_valid = 1;
      if (poke && i == 2) begin start = 1; base_adr = 9; count = 1; end
      acc = 0;
      for (int k = 0; k < 20 && !acc; k++) begin
        acc = s_ready;
        @(posedge clk); #1;
        start = 0;
      end
      check("byte_accept", 64'(acc), 64'd1);
      if (gap) begin
        s_valid = 0;
        if (i % K != K - 1) check("ready_in_collect", 64'(s_ready), 64'd1);
        @(posedge clk); #1;
      end
    end
    s_valid = 0;
    for (int k = 0; k < 40 && !done; k++) begin @(posedge clk); #1; end
    check("done", 64'(done), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    if (!gap) check("cycles", 64'(cyc - t0), 64'(1 + c * (K + 1)));
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n0;
    rst_n = 1; start = 0; s_valid = 0; s_data = 0; base_adr = 0; count = 0;
    #3 rst_n = 0;
    #1;
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_adr", 64'(adr), 64'd0);
    check("rst_din", 64'(din), 64'd0);
    #8 rst_n = 1;
    @(posedge clk); #1;
    run_load(2, 2, 8'h11, 8'h11, 0, 0);
    run_load(2, 2, 8'h11, 8'h11, 1, 0);
    run_load(15, 2, 8'h01, 8'h01, 0, 0);
    run_load(4, 0, 8'h00, 8'h00, 0, 0);
    run_load(2, 2, 8'h11, 8'h11, 0, 1);
    run_load(0, 16, 8'h00, 8'h03, 0, 0);
    n0 = nwr;
    start = 1; base_adr = 3; count = 1;
    @(posedge clk); #1;
    start = 0;
    s_valid = 1; s_data = 8'h5a;
    @(posedge clk); #1;
    s_data = 8'h6b;
    @(posedge clk); #1;
    s_valid = 0;
    #3 rst_n = 0;
    #1 check("abort_we", 64'(we), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    #3 rst_n = 1;
    repeat (8) @(posedge clk);
    #1 check("abort_no_write", 64'(nwr), 64'(n0));
    run_load(5, 1, 8'hAA, 8'h11, 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ram_word_loader.md
Name: ram_word_loader

Overview:
- Upstream feeder for the register-file RAM (N-bit address, M-bit words, address 0 reads as zero).
- Accepts a byte stream over a valid/ready handshake and assembles M-bit words, little-endian.
- Writes the words to consecutive RAM addresses through the RAM's we/adr/din write port.
- Used to preload RAM contents before the datapath runs.

Parameters:
N, 4, RAM address width; must match the RAM.
M, 32, RAM word width; must match the RAM.
B, 8, stream byte width; M must be an integer multiple of B (K = M/B bytes per word).

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle load request; sampled only in IDLE.
base_adr  input  N  first RAM address; latched on accepted start.
count  input  N+1  number of words to load, 0..2^N; latched on accepted start.
s_data  input  B  stream byte.
s_valid  input  1  s_data valid.
s_ready  output  1  loader can accept a byte.
we  output  1  RAM write enable.
adr  output  N  RAM address.
din  output  M  RAM write data.
busy  output  1  high in COLLECT and WRITE.
done  output  1  one-cycle pulse when the load completes.

Behaviour:
- Reset is asynchronous and active-low:
  - State goes to IDLE.
  - s_ready, we, busy and done go to 0.
  - adr and din go to 0.
  - Byte counter, word counter and shift register clear.
- Reset mid-operation aborts the load:
  - Any partial word is discarded.
  - No write is issued.
- All outputs are registered or decoded from registered state. There is no combinational path from s_valid to s_ready.
- States:
  - IDLE:
    - s_ready=0, we=0.
    - start with count!=0: latch base_adr as cur_adr and count as remaining, clear the byte counter, go to COLLECT.
    - start with count==0: go to DONE (no writes).
  - COLLECT:
    - s_ready=1, busy=1.
    - Each cycle with s_valid && s_ready places s_data into bits [B*i+B-1 : B*i], where i is the byte index 0..K-1. The first byte lands in the least-significant position.
    - After the K-th accepted byte, go to WRITE.
    - s_valid low simply stalls the loader. There is no timeout.
  - WRITE:
    - Lasts exactly one cycle: we=1, adr=cur_adr, din=assembled word, s_ready=0.
    - On exit, cur_adr increments modulo 2^N (2^N-1 wraps to 0) and remaining decrements.
    - remaining==0 after the decrement: go to DONE. Otherwise go to COLLECT with the byte counter cleared.
  - DONE:
    - done=1 for one cycle, busy=0.
    - Return to IDLE.
- start outside IDLE is ignored.
- start and s_valid in the same IDLE cycle: the byte is not accepted, because s_ready=0.
- Throughput with s_valid held high: K accept cycles plus 1 write cycle per word (5 cycles for the defaults).
- Total cycles from start to done: 1 + count*(K+1), plus stall cycles.
- With count=2^N, every address is written once.

Optional Feature:
- Macro: LOADER_SKIP_ADR0_EN.
- Defined:
  - The loader never writes address 0, because the RAM returns zero there regardless of content.
  - If the latched base_adr is 0, it becomes 1.
  - Incrementing from 2^N-1 goes to 1.
  - A skipped address does not consume a word from count. count is clamped to 2^N-1 when latched.
- Not defined:
  - Address 0 is written like any other address.
  - Wrap goes from 2^N-1 to 0.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with no clock edge -> s_ready, we, busy and done read 0 immediately; adr and din read 0.
- Basic load: start, base_adr=2, count=2, bytes 11 22 33 44 55 66 77 88 with continuous valid -> we pulses at adr=2 din=0x44332211 and at adr=3 din=0x88776655, each exactly 1 cycle; done pulses one cycle after the second write; busy drops with done.
- Backpressure: same load with s_valid low on alternate cycles -> identical writes; s_ready stays 1 in COLLECT; no byte is lost or duplicated.
- Wrap: base_adr=15, count=2 (N=4), bytes 01..08 -> writes 0x04030201 to address 15, then 0x08070605 to address 0 (macro off) or address 1 (macro on).
- Abort: after 2 bytes accepted, pulse rst_n low -> no we ever asserted. A new start with base_adr=5, count=1 and bytes AA BB CC DD -> adr=5 din=0xDDCCBBAA.
- Edge requests: start with count=0 -> done one cycle later and no we. start pulsed while busy -> ignored; the original load completes unchanged.
